// File: rtl/link_port_bridge.sv
// Bridge between a byte-wide host handshake and a clocked serial link.
// Ports: clk/reset (async active-low); link_sck_in/link_sd_in from the
// serial port; link_sd_out/link_sck_out to it; host_tx_* pushes reply
// bytes into a small FIFO; host_rx_* presents received bytes; busy and
// sticky overrun flags. master_start requests a bridge-clocked byte.
// Optional macro LINK_BRIDGE_MASTER_EN adds the generated-clock mode.
module link_port_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TX_DEPTH    = 4,
    parameter int TIMEOUT     = 4096,
    parameter int MASTER_DIV  = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       link_sck_in,
    input  logic       link_sd_in,
    output logic       link_sd_out,
    output logic       link_sck_out,
    input  logic [7:0] host_tx_data,
    input  logic       host_tx_valid,
    output logic       host_tx_ready,
    output logic [7:0] host_rx_data,
    output logic       host_rx_valid,
    input  logic       host_rx_ready,
    input  logic       master_start,
    output logic       busy,
    output logic       overrun
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef LINK_BRIDGE_MASTER_EN
    localparam int DW = $clog2(MASTER_DIV + 1);
    typedef enum logic [1:0] {
        S_IDLE, S_SHIFT, S_MCLK_LO, S_MCLK_HI
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_SHIFT
    } state_t;
`endif

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic [SYNC_STAGES-1:0] r_arm;
    logic                   r_sck_prev;
    logic [7:0]             r_mem [TX_DEPTH];
    logic [PW-1:0]          r_wr;
    logic [PW-1:0]          r_rd;
    logic [PW:0]            r_cnt;
    logic [7:0]             r_tx;
    logic [6:0]             r_rx;
    logic [2:0]             r_bit;
    logic [TW-1:0]          r_tmo;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_overrun;

    logic       w_sck;
    logic       w_sd;
    logic       w_fall;
    logic       w_rise;
    logic       w_full;
    logic       w_empty;
    logic       w_start;
    logic       w_pop;
    logic       w_push;
    logic       w_rise_ev;
    logic       w_fall_ev;
    logic       w_done;
    logic [7:0] w_tx_load;
    logic [7:0] w_rx_byte;

`ifdef LINK_BRIDGE_MASTER_EN
    logic [DW-1:0] r_div;
    logic          r_sck_out;
    logic          w_div_end;
    assign w_div_end    = (r_div == DW'(MASTER_DIV - 1));
    assign link_sck_out = r_sck_out;
`else
    logic w_unused;
    assign w_unused     = ^{master_start, MASTER_DIV[0]};
    assign link_sck_out = 1'b1;
`endif

    assign w_sck = r_sck_sync[SYNC_STAGES-1];
    assign w_sd  = r_sd_sync[SYNC_STAGES-1];
    // r_arm fills with ones after release, masking edges while the
    // synchronizers still hold their reset value.
    assign w_fall = r_arm[SYNC_STAGES-1] & r_sck_prev & ~w_sck;
    assign w_rise = r_arm[SYNC_STAGES-1] & ~r_sck_prev & w_sck;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync <= '1;
            r_sd_sync  <= '1;
            r_arm      <= '0;
            r_sck_prev <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], link_sck_in};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], link_sd_in};
            r_arm      <= {r_arm[SYNC_STAGES-2:0], 1'b1};
            r_sck_prev <= w_sck;
        end
    end

    assign w_full        = (r_cnt == (PW + 1)'(TX_DEPTH));
    assign w_empty       = (r_cnt == '0);
    assign host_tx_ready = ~w_full;
    assign w_pop         = w_start & ~w_empty;
    assign w_push        = host_tx_valid & (~w_full | w_pop);
    assign w_tx_load     = w_empty ? 8'hFF : r_mem[r_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < TX_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= host_tx_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        w_start   = 1'b0;
        w_rise_ev = 1'b0;
        w_fall_ev = 1'b0;
        case (r_state)
`ifdef LINK_BRIDGE_MASTER_EN
            S_IDLE:    w_start   = w_fall | master_start;
            S_MCLK_LO: w_rise_ev = w_div_end;
            S_MCLK_HI: w_fall_ev = w_div_end;
`else
            S_IDLE:    w_start   = w_fall;
`endif
            S_SHIFT: begin
                w_rise_ev = w_rise;
                w_fall_ev = w_fall;
            end
            default: ;
        endcase
    end

    assign w_done    = w_rise_ev & (r_bit == 3'd7);
    assign w_rx_byte = {r_rx, w_sd};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tx    <= 8'hFF;
            r_rx    <= '0;
            r_bit   <= '0;
            r_tmo   <= '0;
`ifdef LINK_BRIDGE_MASTER_EN
            r_div     <= '0;
            r_sck_out <= 1'b1;
`endif
        end else begin
            if (w_rise_ev) begin
                r_rx  <= w_rx_byte[6:0];
                r_bit <= r_bit + 3'd1;
            end
            // Filling with ones leaves the line high once the byte is out.
            if (w_fall_ev) r_tx <= {r_tx[6:0], 1'b1};
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_start) begin
                        r_tx  <= w_tx_load;
                        r_bit <= '0;
`ifdef LINK_BRIDGE_MASTER_EN
                        if (w_fall) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state   <= S_MCLK_LO;
                            r_sck_out <= 1'b0;
                            r_div     <= '0;
                        end
`else
                        r_state <= S_SHIFT;
`endif
                    end
                end
                S_SHIFT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_tx    <= 8'hFF;
                    end else if (w_rise_ev | w_fall_ev) begin
                        r_tmo <= '0;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                        r_tx    <= 8'hFF;
                        r_tmo   <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
`ifdef LINK_BRIDGE_MASTER_EN
                S_MCLK_LO: begin
                    if (w_div_end) begin
                        r_div     <= '0;
                        r_sck_out <= 1'b1;
                        if (w_done) begin
                            r_state <= S_IDLE;
                            r_tx    <= 8'hFF;
                        end else begin
                            r_state <= S_MCLK_HI;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_MCLK_HI: begin
                    if (w_div_end) begin
                        r_div     <= '0;
                        r_sck_out <= 1'b0;
                        r_state   <= S_MCLK_LO;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A completing byte is kept only if the holding register is free
    // or being accepted in this same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_done) begin
            if (!r_rx_valid || host_rx_ready) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_rx_valid && host_rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign link_sd_out   = r_tx[7];
    assign host_rx_data  = r_rx_data;
    assign host_rx_valid = r_rx_valid;
    assign overrun       = r_overrun;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_link_port_bridge.sv
// Testbench for link_port_bridge: a serial-port peer model drives the
// link, a queue models the reply FIFO and a small model the rx holding.
module tb_link_port_bridge;

    localparam int TXD  = 4;
    localparam int TMO  = 64;
    localparam int MDIV = 4;
    localparam int H    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       link_sck_in = 1'b1;
    logic       link_sd_in = 1'b1;
    logic       link_sd_out;
    logic       link_sck_out;
    logic [7:0] host_tx_data = 8'h00;
    logic       host_tx_valid = 1'b0;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready = 1'b0;
    logic       master_start = 1'b0;
    logic       busy;
    logic       overrun;

    link_port_bridge #(
        .SYNC_STAGES(2),
        .TX_DEPTH(TXD),
        .TIMEOUT(TMO),
        .MASTER_DIV(MDIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .link_sck_in(link_sck_in),
        .link_sd_in(link_sd_in),
        .link_sd_out(link_sd_out),
        .link_sck_out(link_sck_out),
        .host_tx_data(host_tx_data),
        .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data),
        .host_rx_valid(host_rx_valid),
        .host_rx_ready(host_rx_ready),
        .master_start(master_start),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
    endtask

    task automatic do_reset();
        link_sck_in = 1'b1;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        model_reset();
    endtask

    task automatic push(input logic [7:0] b);
        check("tx_ready", host_tx_ready, q.size() < TXD);
        host_tx_data  = b;
        host_tx_valid = 1'b1;
        tick();
        host_tx_valid = 1'b0;
        if (q.size() < TXD) q.push_back(b);
    endtask

    task automatic accept();
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;
        m_valid = 1'b0;
    endtask

    // Peer drives data on its falling edge, samples the bridge before rising.
    task automatic xfer(input logic [7:0] b, input int nbits,
                        input bit ack_last, output logic [7:0] sent);
        sent = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            link_sck_in = 1'b0;
            link_sd_in  = b[7-i];
            repeat (H) tick();
            sent[7-i] = link_sd_out;
            link_sck_in = 1'b1;
            if (ack_last && i == nbits - 1) begin
                tick();
                tick();
                host_rx_ready = 1'b1;
                tick();
                host_rx_ready = 1'b0;
                repeat (H - 3) tick();
            end else begin
                repeat (H) tick();
            end
        end
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] rxb,
                             input bit ack);
        logic [7:0] s;
        logic [7:0] e;
        xfer(rxb, 8, ack, s);
        e = (q.size() > 0) ? q.pop_front() : 8'hFF;
        if (ack || !m_valid) begin
            m_data  = rxb;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        check({tag, "_sent"}, s, e);
        check({tag, "_valid"}, host_rx_valid, m_valid);
        check({tag, "_data"}, host_rx_data, m_data);
        check({tag, "_ovr"}, overrun, m_ovr);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] got;
        logic [7:0] pb;
        logic       prev;
        int         k;

        repeat (2) tick();
        check("rst_sd_out", link_sd_out, 1'b1);
        check("rst_sck_out", link_sck_out, 1'b1);
        check("rst_rx_valid", host_rx_valid, 1'b0);
        check("rst_rx_data", host_rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_tx_ready", host_tx_ready, 1'b1);
        reset = 1'b1;
        repeat (3) tick();

        push(8'hA5);
        full_xfer("basic", 8'h3C, 1'b0);
        accept();

        full_xfer("empty", 8'h00, 1'b0);
        accept();

        full_xfer("hold", 8'h5A, 1'b0);
        full_xfer("same_cyc", 8'h96, 1'b1);
        accept();

        full_xfer("ovr_a", 8'h11, 1'b0);
        full_xfer("ovr_b", 8'h22, 1'b0);
        accept();
        check("ovr_drain_valid", host_rx_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        do_reset();
        check("ovr_cleared", overrun, 1'b0);

        push(8'h77);
        xfer(8'h0F, 3, 1'b0, s);
        void'(q.pop_front());
        check("tmo_busy_mid", busy, 1'b1);
        repeat (TMO + 4) tick();
        check("tmo_busy", busy, 1'b0);
        check("tmo_valid", host_rx_valid, 1'b0);
        check("tmo_sd_out", link_sd_out, 1'b1);
        full_xfer("after_tmo", 8'hE1, 1'b0);
        accept();

        xfer(8'hAA, 4, 1'b0, s);
        reset = 1'b0;
        tick();
        check("rstmid_busy", busy, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (20) tick();
        check("rstmid_valid", host_rx_valid, 1'b0);
        check("rstmid_idle", busy, 1'b0);

        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) push(8'($urandom));
            if ($urandom_range(0, 1) == 1) accept();
            full_xfer("rand", 8'($urandom), 1'b0);
        end

        do_reset();
`ifdef LINK_BRIDGE_MASTER_EN
        push(8'hC3);
        void'(q.pop_front());
        pb   = 8'h5A;
        got  = 8'h00;
        k    = 0;
        prev = link_sck_out;
        for (int c = 0; c < 80; c++) begin
            master_start = (c == 0 || c == 20);
            tick();
            if (prev && !link_sck_out && k < 8) begin
                link_sd_in = pb[7-k];
                k++;
            end
            if (!prev && link_sck_out) got = {got[6:0], link_sd_out};
            prev = link_sck_out;
        end
        master_start = 1'b0;
        check("mst_peer_rx", got, 8'hC3);
        check("mst_host_rx", host_rx_data, 8'h5A);
        check("mst_valid", host_rx_valid, 1'b1);
        check("mst_busy", busy, 1'b0);
        check("mst_sck_idle", link_sck_out, 1'b1);
`else
        master_start = 1'b1;
        tick();
        master_start = 1'b0;
        repeat (5) tick();
        check("nomst_busy", busy, 1'b0);
        check("nomst_sck", link_sck_out, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
